// File: rtl/tlb_pkg.sv
// Shared types and constants for the fully-associative Sv39 TLB.
//   tlb_entry_t : one stored translation (valid, asid, vpn, level, ppn, flags)
//   pte_t       : Sv39 leaf page-table entry layout
//   pg_level_e  : page size of a leaf (1 GiB, 2 MiB, 4 KiB)
package tlb_pkg;

  localparam int unsigned VPN_FIELD_W = 9;
  localparam int unsigned SV39_LEVELS = 3;

  localparam int unsigned ASID_W = 16;
  localparam int unsigned VPN_W  = VPN_FIELD_W * SV39_LEVELS;
  localparam int unsigned PPN_W  = 44;

  // Position of the G bit inside the 8-bit flag field {D,A,G,U,X,W,R,V}.
  localparam int unsigned FLAG_G = 5;

  typedef enum logic [1:0] {
    LVL_1G = 2'd0,
    LVL_2M = 2'd1,
    LVL_4K = 2'd2
  } pg_level_e;

  typedef struct packed {
    logic [9:0]       reserved;
    logic [PPN_W-1:0] ppn;
    logic [1:0]       rsw;
    logic [7:0]       flags;  // D,A,G,U,X,W,R,V
  } pte_t;

  typedef struct packed {
    logic              valid;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
    pg_level_e         level;
    logic [PPN_W-1:0]  ppn;
    logic [7:0]        flags;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_tag_match.sv
// Per-entry tag comparator.
//   entry_i    : stored TLB entry
//   vpn_i      : VPN to compare against, honouring the entry's page level
//   asid_i     : ASID to compare against
//   asid_chk_i : 1 = require ASID equality or a global entry; 0 = ignore ASID
//   match_o    : entry is valid and matches
module tlb_tag_match
  import tlb_pkg::*;
(
  input  tlb_entry_t        entry_i,
  input  logic [VPN_W-1:0]  vpn_i,
  input  logic [ASID_W-1:0] asid_i,
  input  logic              asid_chk_i,
  output logic              match_o
);

  logic asid_ok;
  logic hi_eq, mid_eq, lo_eq;

  assign asid_ok = ~asid_chk_i | (entry_i.asid == asid_i) | entry_i.flags[FLAG_G];

  assign hi_eq  = entry_i.vpn[3*VPN_FIELD_W-1:2*VPN_FIELD_W] ==
                  vpn_i[3*VPN_FIELD_W-1:2*VPN_FIELD_W];
  assign mid_eq = entry_i.vpn[2*VPN_FIELD_W-1:VPN_FIELD_W] ==
                  vpn_i[2*VPN_FIELD_W-1:VPN_FIELD_W];
  assign lo_eq  = entry_i.vpn[VPN_FIELD_W-1:0] == vpn_i[VPN_FIELD_W-1:0];

  always_comb begin
    match_o = entry_i.valid & asid_ok & hi_eq;
    case (entry_i.level)
      LVL_1G:  ;
      LVL_2M:  match_o = match_o & mid_eq;
      default: match_o = match_o & mid_eq & lo_eq;
    endcase
  end

endmodule

// File: rtl/tlb_fa.sv
// Fully-associative Sv39 TLB with one-cycle registered lookup.
//   lookup_*  : translation request (cycle N) / response (cycle N+1)
//   refill_*  : single-cycle write from the page-table walker, blocked by flush
//   flush_*   : SFENCE.VMA-style invalidation, optionally qualified by ASID/VPN
//   plru_*    : hit notification to, and victim index from, the replacement block
module tlb_fa
  import tlb_pkg::*;
#(
  parameter int unsigned ENTRIES    = 8,
  parameter int unsigned ASID_WIDTH = ASID_W,
  parameter int unsigned VPN_WIDTH  = VPN_W,
  parameter int unsigned PPN_WIDTH  = PPN_W,
  localparam int unsigned IdxW      = $clog2(ENTRIES)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  lookup_valid_i,
  input  logic [VPN_WIDTH-1:0]  lookup_vpn_i,
  input  logic [ASID_WIDTH-1:0] lookup_asid_i,
  output logic                  lookup_valid_o,
  output logic                  lookup_hit_o,
  output logic [PPN_WIDTH-1:0]  lookup_ppn_o,
  output logic [7:0]            lookup_flags_o,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  input  logic [VPN_WIDTH-1:0]  refill_vpn_i,
  input  logic [ASID_WIDTH-1:0] refill_asid_i,
  input  logic [63:0]           refill_pte_i,
  input  logic [1:0]            refill_level_i,
  input  logic                  flush_i,
  input  logic                  flush_asid_en_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic                  flush_vpn_en_i,
  input  logic [VPN_WIDTH-1:0]  flush_vpn_i,
  output logic                  plru_hit_o,
  output logic [IdxW-1:0]       plru_idx_o,
  input  logic [IdxW-1:0]       plru_replace_idx_i
);

  tlb_entry_t entries_q [ENTRIES];
  tlb_entry_t entries_d [ENTRIES];

  logic [ENTRIES-1:0] lu_match;
  logic [ENTRIES-1:0] fl_vpn_match;
  logic [ENTRIES-1:0] fl_clear;

  for (genvar g = 0; g < ENTRIES; g++) begin : gen_match
    tlb_tag_match u_lookup_match (
      .entry_i    (entries_q[g]),
      .vpn_i      (lookup_vpn_i),
      .asid_i     (lookup_asid_i),
      .asid_chk_i (1'b1),
      .match_o    (lu_match[g])
    );

    // ASID is qualified separately below so that G entries survive ASID flushes.
    tlb_tag_match u_flush_match (
      .entry_i    (entries_q[g]),
      .vpn_i      (flush_vpn_i),
      .asid_i     (flush_asid_i),
      .asid_chk_i (1'b0),
      .match_o    (fl_vpn_match[g])
    );
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      logic asid_hit;
      asid_hit = (entries_q[i].asid == flush_asid_i) & ~entries_q[i].flags[FLAG_G];
      unique case ({flush_asid_en_i, flush_vpn_en_i})
        2'b00:   fl_clear[i] = 1'b1;
        2'b01:   fl_clear[i] = fl_vpn_match[i];
        2'b10:   fl_clear[i] = asid_hit;
        default: fl_clear[i] = fl_vpn_match[i] & asid_hit;
      endcase
    end
  end

  // Lookup: lowest matching index wins.
  logic [IdxW-1:0]      hit_idx;
  logic                 any_hit;
  tlb_entry_t           hit_entry;
  logic [PPN_WIDTH-1:0] ppn_adj;

  always_comb begin
    hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i]) hit_idx = IdxW'(i);
    end
  end

  assign any_hit   = |lu_match;
  assign hit_entry = entries_q[hit_idx];

  // Superpages pass the low VPN fields straight through to the PPN.
  always_comb begin
    ppn_adj = hit_entry.ppn;
    case (hit_entry.level)
      LVL_1G:  ppn_adj[2*VPN_FIELD_W-1:0] = lookup_vpn_i[2*VPN_FIELD_W-1:0];
      LVL_2M:  ppn_adj[VPN_FIELD_W-1:0]   = lookup_vpn_i[VPN_FIELD_W-1:0];
      default: ;
    endcase
  end

  logic                 valid_d, valid_q;
  logic                 hit_d, hit_q;
  logic [PPN_WIDTH-1:0] ppn_d, ppn_q;
  logic [7:0]           flags_d, flags_q;
  logic [IdxW-1:0]      idx_d, idx_q;

  // A same-cycle flush forces a miss; the request still gets a response.
  assign valid_d = lookup_valid_i;
  assign hit_d   = lookup_valid_i & any_hit & ~flush_i;
  assign ppn_d   = hit_d ? ppn_adj : '0;
  assign flags_d = hit_d ? hit_entry.flags : '0;
  assign idx_d   = hit_d ? hit_idx : '0;

  // Refill victim: lowest invalid entry, else the replacement block's choice.
  logic            refill_acc;
  logic [IdxW-1:0] victim;
  logic            any_free;
  pte_t            pte;
  tlb_entry_t      new_entry;

  assign refill_ready_o = ~flush_i;
  assign refill_acc     = refill_valid_i & ~flush_i;
  assign pte            = pte_t'(refill_pte_i);

  always_comb begin
    victim   = plru_replace_idx_i;
    any_free = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!entries_q[i].valid) begin
        victim   = IdxW'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    new_entry.valid = 1'b1;
    new_entry.asid  = refill_asid_i;
    new_entry.vpn   = refill_vpn_i;
    new_entry.level = pg_level_e'(refill_level_i);
    new_entry.ppn   = pte.ppn;
    new_entry.flags = pte.flags;
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
      if (flush_i && fl_clear[i]) entries_d[i].valid = 1'b0;
    end
    if (refill_acc) entries_d[victim] = new_entry;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      valid_q <= 1'b0;
      hit_q   <= 1'b0;
      ppn_q   <= '0;
      flags_q <= '0;
      idx_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= entries_d[i];
      valid_q <= valid_d;
      hit_q   <= hit_d;
      ppn_q   <= ppn_d;
      flags_q <= flags_d;
      idx_q   <= idx_d;
    end
  end

  assign lookup_valid_o = valid_q;
  assign lookup_hit_o   = hit_q;
  assign lookup_ppn_o   = ppn_q;
  assign lookup_flags_o = flags_q;
  assign plru_hit_o     = valid_q & hit_q;
  assign plru_idx_o     = idx_q;

endmodule
